// File: rtl/encoder_sel_ctrl.sv
// Symbol-frequency accumulator that picks the cheapest of three fixed prefix-code encoders.
// Optional `SEL_OVERRIDE_EN adds force_en/force_sel to override the selection in EVAL2.
module encoder_sel_ctrl #(
  parameter int FREQ_BIT      = 10,
  parameter int TOTAL_LEN_BIT = 16,
  parameter int WIN_BIT       = 10
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [WIN_BIT-1:0]       win_len,
  input  logic                     sym_valid,
  input  logic [2:0]               sym,
  output logic                     sym_ready,
  output logic                     sel_valid,
  output logic [1:0]               encoder_sel,
  output logic [TOTAL_LEN_BIT-1:0] best_len,
  input  logic                     sel_ready,
`ifdef SEL_OVERRIDE_EN
  input  logic                     force_en,
  input  logic [1:0]               force_sel,
`endif
  output logic                     busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_EVAL0,
    S_EVAL1,
    S_EVAL2,
    S_DONE
  } state_t;

  state_t state_q, state_nxt;

  logic [FREQ_BIT-1:0]      bin_q [0:4];
  logic [WIN_BIT-1:0]       cnt_q;
  logic [WIN_BIT-1:0]       wl_q;
  logic [WIN_BIT-1:0]       cnt_inc;
  logic [TOTAL_LEN_BIT-1:0] best_q, best_nxt;
  logic [1:0]               idx_q, idx_nxt;
  logic                     accept;

  logic [TOTAL_LEN_BIT-1:0] e1, e2, e3, e4, e5, sum2345;
  logic [TOTAL_LEN_BIT-1:0] total0, total1, total2;

  assign sym_ready = (state_q == S_ACCUM);
  assign sel_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign accept    = sym_valid && (state_q == S_ACCUM);
  assign cnt_inc   = cnt_q + WIN_BIT'(1);

  assign e1 = TOTAL_LEN_BIT'(bin_q[0]);
  assign e2 = TOTAL_LEN_BIT'(bin_q[1]);
  assign e3 = TOTAL_LEN_BIT'(bin_q[2]);
  assign e4 = TOTAL_LEN_BIT'(bin_q[3]);
  assign e5 = TOTAL_LEN_BIT'(bin_q[4]);

  // Code lengths: enc0 = 1,2,3,4,4  enc1 = 2,2,2,3,3  enc2 = 1,3,3,3,3
  assign total0  = e1 + (e2 << 1) + (e3 << 1) + e3 + (e4 << 2) + (e5 << 2);
  assign total1  = (e1 << 1) + (e2 << 1) + (e3 << 1) + (e4 << 1) + e4 + (e5 << 1) + e5;
  assign sum2345 = e2 + e3 + e4 + e5;
  assign total2  = e1 + (sum2345 << 1) + sum2345;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (start) state_nxt = (win_len == '0) ? S_EVAL0 : S_ACCUM;
      S_ACCUM: if (accept && (cnt_inc == wl_q)) state_nxt = S_EVAL0;
      S_EVAL0: state_nxt = S_EVAL1;
      S_EVAL1: state_nxt = S_EVAL2;
      S_EVAL2: state_nxt = S_DONE;
      S_DONE:  if (sel_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    best_nxt = best_q;
    idx_nxt  = idx_q;
    case (state_q)
      S_EVAL0: begin
        best_nxt = total0;
        idx_nxt  = 2'd0;
      end
      S_EVAL1: begin
        if (total1 < best_q) begin
          best_nxt = total1;
          idx_nxt  = 2'd1;
        end
      end
      S_EVAL2: begin
        if (total2 < best_q) begin
          best_nxt = total2;
          idx_nxt  = 2'd2;
        end
`ifdef SEL_OVERRIDE_EN
        if (force_en) begin
          case (force_sel)
            2'd0: begin
              best_nxt = total0;
              idx_nxt  = 2'd0;
            end
            2'd1: begin
              best_nxt = total1;
              idx_nxt  = 2'd1;
            end
            default: begin
              best_nxt = total2;
              idx_nxt  = 2'd2;
            end
          endcase
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wl_q        <= '0;
      best_q      <= '0;
      idx_q       <= '0;
      encoder_sel <= '0;
      best_len    <= '0;
      for (int unsigned i = 0; i < 5; i++) bin_q[i] <= '0;
    end else begin
      state_q <= state_nxt;
      best_q  <= best_nxt;
      idx_q   <= idx_nxt;
      if ((state_q == S_IDLE) && start) begin
        cnt_q <= '0;
        wl_q  <= win_len;
        for (int unsigned i = 0; i < 5; i++) bin_q[i] <= '0;
      end
      if (accept) begin
        cnt_q <= cnt_inc;
        // Symbols 5..7 advance the window count but touch no bin.
        for (int unsigned i = 0; i < 5; i++) begin
          if ((sym == 3'(i)) && (bin_q[i] != '1)) bin_q[i] <= bin_q[i] + FREQ_BIT'(1);
        end
      end
      // Result outputs only move when the final choice is known.
      if (state_q == S_EVAL2) begin
        encoder_sel <= idx_nxt;
        best_len    <= best_nxt;
      end
    end
  end

endmodule

// File: tb/tb_encoder_sel_ctrl.sv
// Scoreboard bench for encoder_sel_ctrl: stimulus pushes expected results, a negedge monitor pops on handshake.
module tb_encoder_sel_ctrl;
  localparam int FB  = 4;
  localparam int TLB = 16;
  localparam int WB  = 10;

  logic           CLK = 1'b0;
  logic           RST;
  logic           start;
  logic [WB-1:0]  win_len;
  logic           sym_valid;
  logic [2:0]     sym;
  logic           sym_ready;
  logic           sel_valid;
  logic [1:0]     encoder_sel;
  logic [TLB-1:0] best_len;
  logic           sel_ready;
  logic           busy;
`ifdef SEL_OVERRIDE_EN
  logic           force_en;
  logic [1:0]     force_sel;
`endif

  encoder_sel_ctrl #(.FREQ_BIT(FB), .TOTAL_LEN_BIT(TLB), .WIN_BIT(WB)) dut (
    .CLK(CLK), .RST(RST), .start(start), .win_len(win_len),
    .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready),
    .sel_valid(sel_valid), .encoder_sel(encoder_sel), .best_len(best_len),
    .sel_ready(sel_ready),
`ifdef SEL_OVERRIDE_EN
    .force_en(force_en), .force_sel(force_sel),
`endif
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]     sel;
    logic [TLB-1:0] len;
    string          name;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  exp_t       drop_e;
  logic [2:0] stim[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST && sel_valid && sel_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sel=%0d len=%0d expected none", encoder_sel, best_len);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, " encoder_sel"}, 32'(encoder_sel), 32'(mon_e.sel));
        chk({mon_e.name, " best_len"}, 32'(best_len), 32'(mon_e.len));
      end
    end
  end

  task automatic run_window(input string name, input int wl, input logic [1:0] esel,
                            input int elen, input int hold, input bit noisy);
    int lat;
    bit got;
    sb.push_back('{esel, TLB'(elen), name});
    win_len = WB'(wl);
    start   = 1'b1;
    @(posedge CLK); #1;
    start   = 1'b0;
    win_len = '0;
    foreach (stim[i]) begin
      sym_valid = 1'b1;
      sym       = stim[i];
      if (noisy) begin
        start   = 1'b1;
        win_len = WB'(1);
      end
      for (int c = 0; c < 20; c++) begin
        @(negedge CLK);
        if (sym_ready) break;
      end
      if (!sym_ready) chk({name, " sym_ready timeout"}, 32'(sym_ready), 32'd1);
      @(posedge CLK); #1;
    end
    sym_valid = 1'b0;
    start     = 1'b0;
    win_len   = '0;
    lat = 0;
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge CLK);
      if (sel_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk({name, " latency"}, 32'(lat), 32'd4);
    if (!got) begin
      drop_e = sb.pop_back();
      return;
    end
    for (int h = 0; h < hold; h++) begin
      // A start while waiting in DONE must be ignored.
      if (h == 1) begin
        start   = 1'b1;
        win_len = WB'(3);
      end
      @(negedge CLK);
      start = 1'b0;
      chk({name, " hold sel_valid"}, 32'(sel_valid), 32'd1);
      chk({name, " hold busy"}, 32'(busy), 32'd1);
      chk({name, " hold encoder_sel"}, 32'(encoder_sel), 32'(esel));
      chk({name, " hold best_len"}, 32'(best_len), 32'(elen));
    end
    @(posedge CLK); #1;
    sel_ready = 1'b1;
    start     = 1'b1;
    win_len   = '0;
    @(posedge CLK); #1;
    sel_ready = 1'b0;
    start     = 1'b0;
    @(negedge CLK);
    chk({name, " post busy"}, 32'(busy), 32'd0);
    chk({name, " post sel_valid"}, 32'(sel_valid), 32'd0);
    chk({name, " post encoder_sel"}, 32'(encoder_sel), 32'(esel));
    chk({name, " post best_len"}, 32'(best_len), 32'(elen));
  endtask

  task automatic check_reset_state(input string name);
    @(negedge CLK);
    chk({name, " busy"}, 32'(busy), 32'd0);
    chk({name, " sym_ready"}, 32'(sym_ready), 32'd0);
    chk({name, " sel_valid"}, 32'(sel_valid), 32'd0);
    chk({name, " encoder_sel"}, 32'(encoder_sel), 32'd0);
    chk({name, " best_len"}, 32'(best_len), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST       = 1'b1;
    start     = 1'b0;
    win_len   = '0;
    sym_valid = 1'b0;
    sym       = '0;
    sel_ready = 1'b0;
`ifdef SEL_OVERRIDE_EN
    force_en  = 1'b0;
    force_sel = 2'd0;
`endif
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    check_reset_state("reset");

    // Ten sym=0: totals 10/20/10, tie resolves to encoder 0.
    stim = {};
    for (int i = 0; i < 10; i++) stim.push_back(3'd0);
`ifdef SEL_OVERRIDE_EN
    force_en  = 1'b1;
    force_sel = 2'd2;
    run_window("w10_sym0_forced", 10, 2'd2, 10, 0, 1'b0);
    force_en  = 1'b0;
`else
    run_window("w10_sym0", 10, 2'd0, 10, 0, 1'b0);
`endif

    // Four each of sym 2,3,4: totals 44/32/36; stray starts during ACCUM ignored.
    stim = {};
    for (int i = 0; i < 4; i++) stim.push_back(3'd2);
    for (int i = 0; i < 4; i++) stim.push_back(3'd3);
    for (int i = 0; i < 4; i++) stim.push_back(3'd4);
    run_window("w12_mix", 12, 2'd1, 32, 0, 1'b1);

`ifdef SEL_OVERRIDE_EN
    force_en  = 1'b1;
    force_sel = 2'd3;
    run_window("w12_force3", 12, 2'd2, 36, 0, 1'b0);
    force_en  = 1'b0;
`endif

    // Empty window, held in DONE for five cycles.
    stim = {};
    run_window("w0_hold", 0, 2'd0, 0, 5, 1'b0);

    // Twenty sym=1 with 4-bit bins saturate bin2 at 15: totals 30/30/45.
    stim = {};
    for (int i = 0; i < 20; i++) stim.push_back(3'd1);
    run_window("w20_sat", 20, 2'd0, 30, 0, 1'b0);

    // Out-of-range symbols count toward the window only: bin2=1 -> totals 2/2/3.
    stim = {3'd5, 3'd6, 3'd1};
    run_window("w3_oor", 3, 2'd0, 2, 0, 1'b0);

    // Reset in the middle of a window, then a fresh short one.
    win_len = WB'(10);
    start   = 1'b1;
    @(posedge CLK); #1;
    start   = 1'b0;
    sym_valid = 1'b1;
    sym       = 3'd0;
    repeat (5) @(posedge CLK);
    #1;
    sym_valid = 1'b0;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_reset_state("mid_reset");
    stim = {3'd4, 3'd4};
    run_window("w2_after_reset", 2, 2'd1, 6, 0, 1'b0);

    repeat (3) @(negedge CLK);
    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
